line_engine: RTL and testbench

- Graphics-side responder for the processor's line-drawing command interface.
- Latches endpoint coordinates and colour strobed by the CPU, then on trigger rasterises the segment with integer Bresenham (all octants).
- Emits one frame-buffer pixel write per point over a valid/ready port toward the memory/arbiter.
- Deasserts line_ready while busy, which the CPU uses to gate new commands.

---
 rtl/line_engine.sv | 165 ++++++++++++++++
 tb/tb_line_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_engine.sv
// line_engine: CPU-driven line rasteriser.
// Stages endpoints and colour from CPU strobes. On trigger it walks the
// segment with integer Bresenham (all octants) and issues one frame-buffer
// pixel write per point over a valid/ready port.
module line_engine #(
    parameter logic [31:0] FB_BASE = 32'h1000_0000,
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        line_color,
    input  logic [COORD_W-1:0] line_point,
    input  logic               line_color_valid,
    input  logic               line_x0_valid,
    input  logic               line_y0_valid,
    input  logic               line_x1_valid,
    input  logic               line_y1_valid,
    input  logic               line_trigger,
    output logic               line_ready,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [31:0]        pix_addr,
    output logic [23:0]        pix_color
);

    // Error-term width: 2*err must not overflow for full-range coordinates.
    localparam int unsigned AW = COORD_W + 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t state;

    // Staging registers written by the CPU strobes
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [23:0]        color_q;

    // Bresenham walker state
    logic [COORD_W-1:0]   cur_x, cur_y;
    logic signed [AW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;

    // Only the low 24 colour bits are meaningful
    logic unused_color_hi;
    assign unused_color_hi = ^line_color[31:24];

    // Byte address of a pixel: FB_BASE + {y, x, 2'b00}
    function automatic logic [31:0] addr_of(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
        return FB_BASE + ((32'(y) << (COORD_W + 2)) | (32'(x) << 2));
    endfunction

    // Setup arithmetic: absolute deltas of the staged endpoints
    logic signed [AW-1:0] x0_s, y0_s, x1_s, y1_s;
    logic signed [AW-1:0] adx, ady;

    // Absolute x/y deltas of the staged endpoints, used by SETUP
    always_comb begin
        x0_s = signed'(AW'(x0_q));
        y0_s = signed'(AW'(y0_q));
        x1_s = signed'(AW'(x1_q));
        y1_s = signed'(AW'(y1_q));
        adx  = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
        ady  = (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);
    end

    // One Bresenham step from the current point; both tests use the old err
    logic signed [AW-1:0] e2, err_next;
    logic                 step_x, step_y, at_end;
    logic [COORD_W-1:0]   nx, ny;

    // Next point, next error term and end-of-line detect for the walker
    always_comb begin
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err;
        nx       = cur_x;
        ny       = cur_y;
        if (step_x) begin
            err_next = err_next + dy;
            nx       = sx_neg ? (cur_x - COORD_W'(1)) : (cur_x + COORD_W'(1));
        end
        if (step_y) begin
            err_next = err_next + dx;
            ny       = sy_neg ? (cur_y - COORD_W'(1)) : (cur_y + COORD_W'(1));
        end
        at_end = (cur_x == x1_q) && (cur_y == y1_q);
    end

    // Control FSM: staging, setup, and pixel emission with backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_ready <= 1'b1;
            pix_valid  <= 1'b0;
            pix_addr   <= FB_BASE;
            pix_color  <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_color_valid) color_q <= line_color[23:0];
                    if (line_x0_valid)    x0_q    <= line_point;
                    if (line_y0_valid)    y0_q    <= line_point;
                    if (line_x1_valid)    x1_q    <= line_point;
                    if (line_y1_valid)    y1_q    <= line_point;
                    if (line_trigger) begin
                        state      <= SETUP;
                        line_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    dx        <= adx;
                    dy        <= -ady;
                    err       <= adx - ady;
                    sx_neg    <= !(x0_q < x1_q);
                    sy_neg    <= !(y0_q < y1_q);
                    cur_x     <= x0_q;
                    cur_y     <= y0_q;
                    pix_color <= color_q;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (!pix_valid) begin
                        // First DRAW cycle presents the start point
                        pix_valid <= 1'b1;
                        pix_addr  <= addr_of(cur_x, cur_y);
                    end else if (pix_ready) begin
                        if (at_end) begin
                            state      <= IDLE;
                            pix_valid  <= 1'b0;
                            line_ready <= 1'b1;
                        end else begin
                            err      <= err_next;
                            cur_x    <= nx;
                            cur_y    <= ny;
                            pix_addr <= addr_of(nx, ny);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    line_ready <= 1'b1;
                    pix_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed bench for line_engine with hand-computed pixel lists.
module tb_line_engine;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] line_color;
    logic [9:0]  line_point;
    logic        line_color_valid, line_x0_valid, line_y0_valid;
    logic        line_x1_valid, line_y1_valid, line_trigger;
    logic        line_ready, pix_valid, pix_ready;
    logic [31:0] pix_addr;
    logic [23:0] pix_color;

    always #5 clk = ~clk;

    line_engine #(.FB_BASE(BASE), .COORD_W(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .line_color       (line_color),
        .line_point       (line_point),
        .line_color_valid (line_color_valid),
        .line_x0_valid    (line_x0_valid),
        .line_y0_valid    (line_y0_valid),
        .line_x1_valid    (line_x1_valid),
        .line_y1_valid    (line_y1_valid),
        .line_trigger     (line_trigger),
        .line_ready       (line_ready),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_addr         (pix_addr),
        .pix_color        (pix_color)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cap_addr[$];
    logic [23:0] cap_color[$];
    int          exp_x[$];
    int          exp_y[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pt_addr(input int x, input int y);
        return BASE + 32'(y * 4096 + x * 4);
    endfunction

    // One strobe pulse; which: 0=x0 1=y0 2=x1 3=y1
    task automatic strobe(input int which, input int v);
        @(negedge clk);
        line_point = 10'(v);
        case (which)
            0: line_x0_valid = 1'b1;
            1: line_y0_valid = 1'b1;
            2: line_x1_valid = 1'b1;
            default: line_y1_valid = 1'b1;
        endcase
        @(negedge clk);
        line_x0_valid = 1'b0; line_y0_valid = 1'b0;
        line_x1_valid = 1'b0; line_y1_valid = 1'b0;
        line_color_valid = 1'b0;
    endtask

    task automatic stage(input int x0, input int y0, input int x1, input int y1,
                         input logic [31:0] col);
        line_color = col;
        line_color_valid = 1'b1;  // rides along with the x0 strobe
        strobe(0, x0);
        strobe(1, y0);
        strobe(2, x1);
        strobe(3, y1);
    endtask

    // Trigger a line and capture handshaked pixels.
    // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: ready always, inject busy strobes
    task automatic run_line(input int mode, input bit y1_late, input int y1_val);
        int  cyc, lat, last_hs, ready_cyc, stall_err;
        bit  done, have_stall;
        logic [31:0] st_addr;
        logic [23:0] st_color;
        cap_addr.delete();
        cap_color.delete();
        cyc = 0; lat = -1; last_hs = -1; ready_cyc = -1; stall_err = 0;
        done = 1'b0; have_stall = 1'b0;
        @(negedge clk);
        line_trigger = 1'b1;
        pix_ready    = 1'b0;
        if (y1_late) begin
            line_point    = 10'(y1_val);
            line_y1_valid = 1'b1;
        end
        @(negedge clk);
        line_trigger  = 1'b0;
        line_y1_valid = 1'b0;
        while (!done && cyc < 200) begin
            if (mode == 2 && cyc == 3) begin
                line_trigger  = 1'b1;
                line_x1_valid = 1'b1;
                line_point    = 10'd900;
            end else if (mode == 2 && cyc == 4) begin
                line_trigger  = 1'b0;
                line_x1_valid = 1'b0;
            end
            if (have_stall) begin
                if (!pix_valid || pix_addr !== st_addr || pix_color !== st_color)
                    stall_err++;
                have_stall = 1'b0;
            end
            if (line_ready) begin
                done      = 1'b1;
                ready_cyc = cyc;
            end else begin
                if (pix_valid && lat < 0) lat = cyc;
                pix_ready = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
                if (pix_valid && pix_ready) begin
                    cap_addr.push_back(pix_addr);
                    cap_color.push_back(pix_color);
                    last_hs = cyc;
                end else if (pix_valid) begin
                    have_stall = 1'b1;
                    st_addr    = pix_addr;
                    st_color   = pix_color;
                end
                @(negedge clk);
                cyc++;
            end
        end
        line_trigger  = 1'b0;
        line_x1_valid = 1'b0;
        check("line_done", 32'(done), 32'd1);
        check("first_valid_latency", 32'(lat), 32'd2);
        check("ready_after_last", 32'(ready_cyc), 32'(last_hs + 1));
        check("valid_low_idle", 32'(pix_valid), 32'd0);
        if (mode == 1) check("stall_hold", 32'(stall_err), 32'd0);
    endtask

    task automatic verify_line(input logic [23:0] col);
        int n;
        check("pix_count", 32'(cap_addr.size()), 32'(exp_x.size()));
        n = (cap_addr.size() < exp_x.size()) ? cap_addr.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("addr[%0d]", i), cap_addr[i], pt_addr(exp_x[i], exp_y[i]));
            check($sformatf("color[%0d]", i), 32'(cap_color[i]), 32'(col));
        end
    endtask

    task automatic set_exp(input int xs[$], input int ys[$]);
        exp_x = xs;
        exp_y = ys;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int hs, cyc;
        rst_n = 1'b0;
        line_color = '0; line_point = '0;
        line_color_valid = 1'b0; line_x0_valid = 1'b0; line_y0_valid = 1'b0;
        line_x1_valid = 1'b0; line_y1_valid = 1'b0; line_trigger = 1'b0;
        pix_ready = 1'b0;
        #12;
        check("rst_line_ready", 32'(line_ready), 32'd1);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_addr", pix_addr, BASE);
        check("rst_pix_color", 32'(pix_color), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Horizontal line
        stage(0, 0, 3, 0, 32'h00FF_0000);
        run_line(0, 1'b0, 0);
        set_exp('{0, 1, 2, 3}, '{0, 0, 0, 0});
        verify_line(24'hFF0000);
        check("t1_first_addr", cap_addr.size() > 0 ? cap_addr[0] : 32'hX, 32'h1000_0000);

        // Steep reversed line; upper colour byte is discarded
        stage(2, 5, 0, 0, 32'h12AB_CDEF);
        run_line(0, 1'b0, 0);
        set_exp('{2, 2, 1, 1, 0, 0}, '{5, 4, 3, 2, 1, 0});
        verify_line(24'hABCDEF);
        check("t2_first_addr", cap_addr.size() > 0 ? cap_addr[0] : 32'hX, 32'h1000_5008);

        // Busy protection: trigger and x1=900 strobe during the draw are dropped
        run_line(2, 1'b0, 0);
        verify_line(24'hABCDEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_second_line", 32'(pix_valid), 32'd0);
        end
        // Staging persisted and x1 unchanged: identical redraw
        run_line(0, 1'b0, 0);
        verify_line(24'hABCDEF);

        // Degenerate point; y1 strobed in the trigger cycle
        stage(5, 5, 5, 0, 32'h0000_00A5);
        run_line(0, 1'b1, 5);
        set_exp('{5}, '{5});
        verify_line(24'h0000A5);
        check("t3_addr", cap_addr.size() > 0 ? cap_addr[0] : 32'hX, 32'h1000_5014);

        // Backpressure
        stage(0, 0, 7, 3, 32'h0055_AA33);
        run_line(1, 1'b0, 0);
        set_exp('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 1, 1, 2, 2, 3, 3});
        verify_line(24'h55AA33);

        // Reset in the middle of a 10-pixel line
        stage(0, 0, 9, 0, 32'h0012_3456);
        @(negedge clk);
        line_trigger = 1'b1;
        pix_ready    = 1'b1;
        @(negedge clk);
        line_trigger = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 2 && cyc < 50) begin
            if (pix_valid && pix_ready) hs++;
            @(negedge clk);
            cyc++;
        end
        check("hs_before_rst", 32'(hs), 32'd2);
        check("busy_before_rst", 32'(line_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_line_ready", 32'(line_ready), 32'd1);
        check("mid_rst_pix_addr", pix_addr, BASE);
        check("mid_rst_pix_color", 32'(pix_color), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(pix_valid), 32'd0);
        end
        // Cleared staging: single pixel at (0,0) in colour 0
        run_line(0, 1'b0, 0);
        set_exp('{0}, '{0});
        verify_line(24'h000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
